switch_debounce_counter: RTL and testbench



---
 rtl/switch_debounce_pkg.sv | 22 ++
 rtl/input_synchronizer.sv | 27 ++
 rtl/switch_debounce_counter.sv | 183 ++++++++++++++++++
 tb/tb_switch_debounce_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared types and defaults for the push-button debounce/press-counter block.
// Optional long-press support is enabled by defining SWITCH_DEBOUNCE_LONG_PRESS_EN.
package switch_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_e;

    typedef logic [3:0] press_count_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES   = 250000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 25000000;

    // Free-running 4-bit press count; the wrap 15->0 is intentional and silent.
    function automatic press_count_t press_count_inc(input press_count_t count);
        return count + press_count_t'(1);
    endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchroniser for an asynchronous single-bit input, cleared by a
// synchronous active-high reset. Reusable for the other board buttons.
module input_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debounce_counter.sv
// Synchronised, debounced push-button with press/release strobes and a 4-bit
// press count on the LEDs. Define SWITCH_DEBOUNCE_LONG_PRESS_EN for long-press.
module switch_debounce_counter
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES       = 2,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic i_Clk,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_Level,
    output logic o_Pressed,
    output logic o_Released,
    output logic o_Long_Press,
    output logic o_LED_1,
    output logic o_LED_2,
    output logic o_LED_3,
    output logic o_LED_4
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_params
        $error("switch_debounce_counter: parameter out of legal range");
    end

    logic         sync;
    db_state_e    state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic         level_q,    level_d;
    logic         pressed_q,  pressed_d;
    logic         released_q, released_d;
    press_count_t count_q,    count_d;
    logic         enter_high;
    logic         enter_low;

    input_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (i_Clk),
        .rst_i   (i_Switch_1),
        .async_i (i_Switch_2),
        .sync_o  (sync)
    );

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Switch_1) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter idles at zero outside the WAIT states
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE_LOW: begin
                if (sync) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!sync)                 state_d = IDLE_LOW;
                else if (cnt_q == CNT_LAST) state_d = IDLE_HIGH;
                else                       cnt_d   = cnt_q + CNT_W'(1);
            end
            IDLE_HIGH: begin
                if (!sync) state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (sync)                  state_d = IDLE_HIGH;
                else if (cnt_q == CNT_LAST) state_d = IDLE_LOW;
                else                       cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE_LOW;
        endcase
    end

    // Only an accepted transition counts; a rejected glitch in WAIT_x falls back silently
    assign enter_high = (state_q == WAIT_HIGH) && (state_d == IDLE_HIGH);
    assign enter_low  = (state_q == WAIT_LOW)  && (state_d == IDLE_LOW);

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = (LONG_PRESS_CYCLES > 2) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              fired_q, fired_d;
    logic              long_q, long_d;

    // Output logic
    always_comb begin
        level_d    = level_q;
        pressed_d  = enter_high;
        released_d = enter_low;
        count_d    = count_q;
        hold_d     = '0;
        fired_d    = 1'b0;
        long_d     = 1'b0;
        if (enter_high) begin
            level_d = 1'b1;
            count_d = press_count_inc(count_q);
        end
        if (enter_low) begin
            level_d = 1'b0;
        end
        // Hold timer saturates at its last value; the fired flag allows one pulse per hold
        if (state_q == IDLE_HIGH && state_d == IDLE_HIGH) begin
            hold_d  = hold_q;
            fired_d = fired_q;
            if (hold_q == HOLD_LAST) begin
                if (!fired_q) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                    count_d = '0;
                end
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Switch_1) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign o_Long_Press = long_q;
`else
    // Output logic
    always_comb begin
        level_d    = level_q;
        pressed_d  = enter_high;
        released_d = enter_low;
        count_d    = count_q;
        if (enter_high) begin
            level_d = 1'b1;
            count_d = press_count_inc(count_q);
        end
        if (enter_low) begin
            level_d = 1'b0;
        end
    end

    assign o_Long_Press = 1'b0;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Switch_1) begin
            level_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            count_q    <= '0;
        end else begin
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            count_q    <= count_d;
        end
    end

    assign o_Level    = level_q;
    assign o_Pressed  = pressed_q;
    assign o_Released = released_q;
    assign o_LED_1    = count_q[0];
    assign o_LED_2    = count_q[1];
    assign o_LED_3    = count_q[2];
    assign o_LED_4    = count_q[3];

endmodule

// File: tb/tb_switch_debounce_counter.sv
// Directed bench for switch_debounce_counter (DEBOUNCE=4, SYNC=2, LONG=10);
// long-press expectations follow SWITCH_DEBOUNCE_LONG_PRESS_EN.
module tb_switch_debounce_counter;

    logic clk = 1'b0;
    logic rst;
    logic raw;
    logic level, pressed, released, long_press;
    logic led1, led2, led3, led4;

    int checks   = 0;
    int failures = 0;
    int n_press  = 0;
    int n_rel    = 0;
    int n_long   = 0;
    int n_both   = 0;

    always #5 clk = ~clk;

    switch_debounce_counter #(
        .DEBOUNCE_CYCLES   (4),
        .SYNC_STAGES       (2),
        .LONG_PRESS_CYCLES (10)
    ) dut (
        .i_Clk        (clk),
        .i_Switch_1   (rst),
        .i_Switch_2   (raw),
        .o_Level      (level),
        .o_Pressed    (pressed),
        .o_Released   (released),
        .o_Long_Press (long_press),
        .o_LED_1      (led1),
        .o_LED_2      (led2),
        .o_LED_3      (led3),
        .o_LED_4      (led4)
    );

    // Strobe counters sampled shortly after each active edge
    always @(posedge clk) begin
        #1;
        if (pressed === 1'b1)    n_press++;
        if (released === 1'b1)   n_rel++;
        if (long_press === 1'b1) n_long++;
        if (pressed === 1'b1 && released === 1'b1) n_both++;
    end

    function automatic logic [3:0] leds();
        return {led4, led3, led2, led1};
    endfunction

    function automatic logic [7:0] all_outs();
        return {level, pressed, released, long_press, led4, led3, led2, led1};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic press_clean();
        raw = 1'b1;
        step(10);
        raw = 1'b0;
        step(10);
    endtask

    initial begin
        logic [7:0] bad;
        int base_p, base_r, base_l;

        // 1. reset then idle
        rst = 1'b1;
        raw = 1'b0;
        step(2);
        chk("reset_outputs", 32'(all_outs()), 32'h0);
        rst = 1'b0;
        bad = '0;
        repeat (50) begin
            step(1);
            bad |= all_outs();
        end
        chk("idle_outputs", 32'(bad), 32'h0);

        // 2. clean press: accepted on the 7th edge after raw rises
        raw = 1'b1;
        step(6);
        chk("press_not_early", 32'({level, pressed}), 32'h0);
        step(1);
        chk("press_level", 32'(level), 32'h1);
        chk("press_strobe", 32'(pressed), 32'h1);
        chk("press_leds", 32'(leds()), 32'h1);
        step(1);
        chk("press_strobe_one_cycle", 32'({level, pressed}), 32'h2);
        raw = 1'b0;
        step(6);
        chk("release_not_early", 32'({level, released}), 32'h2);
        step(1);
        chk("release_strobe", 32'({level, released}), 32'h1);
        step(1);
        chk("release_one_cycle", 32'(released), 32'h0);
        chk("release_leds", 32'(leds()), 32'h1);

        // 3. bounce: 1,2,3-cycle pulses then stable high
        do_reset();
        base_p = n_press;
        raw = 1'b1; step(1); raw = 1'b0; step(3);
        raw = 1'b1; step(2); raw = 1'b0; step(3);
        raw = 1'b1; step(3); raw = 1'b0; step(3);
        raw = 1'b1;
        step(6);
        chk("bounce_no_press", 32'(n_press - base_p), 32'd0);
        chk("bounce_level_low", 32'(level), 32'h0);
        step(1);
        chk("bounce_press", 32'(pressed), 32'h1);
        step(5);
        chk("bounce_one_press", 32'(n_press - base_p), 32'd1);
        chk("bounce_leds", 32'(leds()), 32'h1);
        raw = 1'b0;
        step(10);

        // 4. wrap after 16 presses
        do_reset();
        base_p = n_press;
        base_r = n_rel;
        for (int i = 0; i < 15; i++) press_clean();
        chk("wrap_leds_15", 32'(leds()), 32'hF);
        press_clean();
        chk("wrap_leds_0", 32'(leds()), 32'h0);
        chk("wrap_presses", 32'(n_press - base_p), 32'd16);
        chk("wrap_releases", 32'(n_rel - base_r), 32'd16);

        // 5. reset two cycles into WAIT_HIGH with the button held
        do_reset();
        base_p = n_press;
        raw = 1'b1;
        step(4);
        rst = 1'b1;
        step(2);
        chk("midreset_outputs", 32'(all_outs()), 32'h0);
        rst = 1'b0;
        step(6);
        chk("midreset_no_press", 32'(n_press - base_p), 32'd0);
        step(1);
        chk("midreset_press", 32'(pressed), 32'h1);
        chk("midreset_leds", 32'(leds()), 32'h1);
        raw = 1'b0;
        step(10);

        // 6. long press: hold 30 cycles after acceptance
        do_reset();
        base_l = n_long;
        chk("no_long_before", 32'(base_l), 32'd0);
        raw = 1'b1;
        step(7);
        chk("long_press_accept", 32'(pressed), 32'h1);
        step(9);
        chk("long_not_early", 32'(long_press), 32'h0);
        step(1);
`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
        chk("long_strobe", 32'(long_press), 32'h1);
        chk("long_leds_cleared", 32'(leds()), 32'h0);
        step(20);
        chk("long_once", 32'(n_long - base_l), 32'd1);
        chk("long_leds_after", 32'(leds()), 32'h0);
`else
        chk("long_strobe_off", 32'(long_press), 32'h0);
        step(20);
        chk("long_never", 32'(n_long - base_l), 32'd0);
        chk("long_leds_after", 32'(leds()), 32'h1);
`endif
        raw = 1'b0;
        step(7);
        chk("long_release", 32'({level, released}), 32'h1);

        chk("no_overlap", 32'(n_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
